// File: rtl/growl_ctrl_pkg.sv
// Shared types and constants for the growl execute control path.
// Holds the sequencer state enum, instruction classes, ALU opcodes,
// flag masks, opcode match/mask pairs and the decoded control bundle.
package growl_ctrl_pkg;

  localparam int unsigned INST_W   = 16;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned IMM_W    = 8;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_EXEC,
    ST_BRANCH,
    ST_LPM_WAIT,
    ST_LPM_WB
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_BRANCH,
    CL_RJMP,
    CL_LPM,
    CL_ILLEGAL
  } inst_class_t;

  localparam logic [ALU_OP_W-1:0] ALU_ADD   = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_ADC   = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_SBC   = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_AND   = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_OR    = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_EOR   = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_PASSB = 4'd7;

  localparam logic [7:0] FM_ARITH = 8'h3F;
  localparam logic [7:0] FM_LOGIC = 8'h1E;
  localparam logic [7:0] FM_NONE  = 8'h00;

  localparam logic [1:0] ASEL_RD   = 2'd0;
  localparam logic [1:0] ASEL_SREG = 2'd1;
  localparam logic [1:0] ASEL_TEMP = 2'd2;

  // Opcode masks
  localparam logic [INST_W-1:0] MASK_RR   = 16'hFC00;
  localparam logic [INST_W-1:0] MASK_IMM  = 16'hF000;
  localparam logic [INST_W-1:0] MASK_LPMZ = 16'hFE0F;

  // Opcode match values
  localparam logic [INST_W-1:0] OP_ADD  = 16'h0C00;
  localparam logic [INST_W-1:0] OP_ADC  = 16'h1C00;
  localparam logic [INST_W-1:0] OP_SUB  = 16'h1800;
  localparam logic [INST_W-1:0] OP_SBC  = 16'h0800;
  localparam logic [INST_W-1:0] OP_AND  = 16'h2000;
  localparam logic [INST_W-1:0] OP_EOR  = 16'h2400;
  localparam logic [INST_W-1:0] OP_OR   = 16'h2800;
  localparam logic [INST_W-1:0] OP_MOV  = 16'h2C00;
  localparam logic [INST_W-1:0] OP_CP   = 16'h1400;
  localparam logic [INST_W-1:0] OP_CPI  = 16'h3000;
  localparam logic [INST_W-1:0] OP_SUBI = 16'h5000;
  localparam logic [INST_W-1:0] OP_ORI  = 16'h6000;
  localparam logic [INST_W-1:0] OP_ANDI = 16'h7000;
  localparam logic [INST_W-1:0] OP_LDI  = 16'hE000;
  localparam logic [INST_W-1:0] OP_RJMP = 16'hC000;
  localparam logic [INST_W-1:0] OP_BRBS = 16'hF000;
  localparam logic [INST_W-1:0] OP_BRBC = 16'hF400;
  localparam logic [INST_W-1:0] OP_LPM0 = 16'h95C8;
  localparam logic [INST_W-1:0] OP_LPMZ = 16'h9004;
  localparam logic [INST_W-1:0] OP_NOP  = 16'h0000;

  typedef struct packed {
    logic [1:0]          alu_a_sel;
    logic                alu_b_sel;
    logic [ALU_OP_W-1:0] alu_op;
    logic [7:0]          flags_mask;
    logic                branch_mode;
    logic                pc_offset_mode;
    logic [REG_AW-1:0]   rd_addr;
    logic [REG_AW-1:0]   rr_addr;
    logic [IMM_W-1:0]    imm;
    logic                rd_we;
    logic                sreg_we;
  } ctrl_t;

  function automatic logic op_is(input logic [INST_W-1:0] ir,
                                 input logic [INST_W-1:0] mask,
                                 input logic [INST_W-1:0] match);
    return (ir & mask) == match;
  endfunction

endpackage

// File: rtl/inst_decode.sv
// Combinational instruction decoder for the execute sequencer.
// Ports: ir (instruction register) -> ctrl (execute control bundle),
//        cls (instruction class steering the sequencer FSM).
module inst_decode
  import growl_ctrl_pkg::*;
(
  input  logic [INST_W-1:0] ir,
  output ctrl_t             ctrl,
  output inst_class_t       cls
);

  function automatic ctrl_t with_alu(input ctrl_t base, input logic [ALU_OP_W-1:0] op,
                                     input logic [7:0] fm, input logic wr_rd,
                                     input logic wr_sreg);
    base.alu_op     = op;
    base.flags_mask = fm;
    base.rd_we      = wr_rd;
    base.sreg_we    = wr_sreg;
    return base;
  endfunction

  // Immediate forms only reach the upper register half
  function automatic ctrl_t with_imm(input ctrl_t base);
    base.alu_b_sel = 1'b1;
    base.rd_addr   = {1'b1, base.rd_addr[3:0]};
    return base;
  endfunction

  always_comb begin
    ctrl         = '0;
    cls          = CL_ILLEGAL;
    ctrl.rd_addr = {ir[8], ir[7:4]};
    ctrl.rr_addr = {ir[9], ir[3:0]};
    ctrl.imm     = {ir[11:8], ir[3:0]};

    if (ir == OP_NOP) begin
      cls = CL_ALU;
    end else if (op_is(ir, MASK_RR, OP_ADD)) begin
      cls = CL_ALU; ctrl = with_alu(ctrl, ALU_ADD, FM_ARITH, 1'b1, 1'b1);
    end else if (op_is(ir, MASK_RR, OP_ADC)) begin
      cls = CL_ALU; ctrl = with_alu(ctrl, ALU_ADC, FM_ARITH, 1'b1, 1'b1);
    end else if (op_is(ir, MASK_RR, OP_SUB)) begin
      cls = CL_ALU; ctrl = with_alu(ctrl, ALU_SUB, FM_ARITH, 1'b1, 1'b1);
    end else if (op_is(ir, MASK_RR, OP_SBC)) begin
      cls = CL_ALU; ctrl = with_alu(ctrl, ALU_SBC, FM_ARITH, 1'b1, 1'b1);
    end else if (op_is(ir, MASK_RR, OP_AND)) begin
      cls = CL_ALU; ctrl = with_alu(ctrl, ALU_AND, FM_LOGIC, 1'b1, 1'b1);
    end else if (op_is(ir, MASK_RR, OP_OR)) begin
      cls = CL_ALU; ctrl = with_alu(ctrl, ALU_OR, FM_LOGIC, 1'b1, 1'b1);
    end else if (op_is(ir, MASK_RR, OP_EOR)) begin
      cls = CL_ALU; ctrl = with_alu(ctrl, ALU_EOR, FM_LOGIC, 1'b1, 1'b1);
    end else if (op_is(ir, MASK_RR, OP_MOV)) begin
      cls = CL_ALU; ctrl = with_alu(ctrl, ALU_PASSB, FM_NONE, 1'b1, 1'b0);
    end else if (op_is(ir, MASK_RR, OP_CP)) begin
      cls = CL_ALU; ctrl = with_alu(ctrl, ALU_SUB, FM_ARITH, 1'b0, 1'b1);
    end else if (op_is(ir, MASK_IMM, OP_SUBI)) begin
      cls = CL_ALU; ctrl = with_imm(with_alu(ctrl, ALU_SUB, FM_ARITH, 1'b1, 1'b1));
    end else if (op_is(ir, MASK_IMM, OP_ANDI)) begin
      cls = CL_ALU; ctrl = with_imm(with_alu(ctrl, ALU_AND, FM_LOGIC, 1'b1, 1'b1));
    end else if (op_is(ir, MASK_IMM, OP_ORI)) begin
      cls = CL_ALU; ctrl = with_imm(with_alu(ctrl, ALU_OR, FM_LOGIC, 1'b1, 1'b1));
    end else if (op_is(ir, MASK_IMM, OP_CPI)) begin
      cls = CL_ALU; ctrl = with_imm(with_alu(ctrl, ALU_SUB, FM_ARITH, 1'b0, 1'b1));
    end else if (op_is(ir, MASK_IMM, OP_LDI)) begin
      cls = CL_ALU; ctrl = with_imm(with_alu(ctrl, ALU_PASSB, FM_NONE, 1'b1, 1'b0));
    end else if (op_is(ir, MASK_IMM, OP_RJMP)) begin
      cls = CL_RJMP;
      ctrl.pc_offset_mode = 1'b1;
    end else if (op_is(ir, MASK_RR, OP_BRBS) || op_is(ir, MASK_RR, OP_BRBC)) begin
      // sreg AND one-hot bit: ALU Z=1 means the tested flag is clear
      cls              = CL_BRANCH;
      ctrl.alu_a_sel   = ASEL_SREG;
      ctrl.alu_b_sel   = 1'b1;
      ctrl.alu_op      = ALU_AND;
      ctrl.imm         = IMM_W'(8'd1 << ir[2:0]);
      ctrl.branch_mode = ir[10];
    end else if (ir == OP_LPM0) begin
      cls          = CL_LPM;
      ctrl.rd_addr = '0;
    end else if (op_is(ir, MASK_LPMZ, OP_LPMZ)) begin
      cls = CL_LPM;
    end
  end

endmodule

// File: rtl/execute_sequencer.sv
// Multi-cycle control sequencer for the growl execute stage.
// Ports: clk/rst (sync active-high); inst_valid/inst/inst_ready fetch
// handshake; branch_taken from execute; pm_req/pm_ack program-memory
// handshake for LPM; c_* execute selects; rd_addr/rr_addr/imm operands;
// rd_we/sreg_we/pc_inc/pc_load update strobes; illegal opcode pulse.
module execute_sequencer
  import growl_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_valid,
  input  logic [INST_W-1:0]   inst,
  output logic                inst_ready,
  input  logic                branch_taken,
  input  logic                pm_ack,
  output logic                pm_req,
  output logic [1:0]          c_alu_a_sel,
  output logic                c_alu_b_sel,
  output logic [ALU_OP_W-1:0] c_alu_op,
  output logic [7:0]          c_flags_mask,
  output logic                c_new_sreg_sel,
  output logic                c_ex_out,
  output logic                c_branch_mode,
  output logic                c_pc_offset_mode,
  output logic [REG_AW-1:0]   rd_addr,
  output logic [REG_AW-1:0]   rr_addr,
  output logic [IMM_W-1:0]    imm,
  output logic                rd_we,
  output logic                sreg_we,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                illegal
);

  state_t            state;
  state_t            state_next;
  logic [INST_W-1:0] ir;
  ctrl_t             ctrl;
  inst_class_t       cls;

  inst_decode u_inst_decode (
    .ir   (ir),
    .ctrl (ctrl),
    .cls  (cls)
  );

  // State and instruction register; inst only captured on a FETCH handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (state == ST_FETCH && inst_valid) ir <= inst;
    end
  end

  // Next state and control outputs; everything is held at zero during reset
  always_comb begin
    state_next       = state;
    inst_ready       = 1'b0;
    pm_req           = 1'b0;
    c_alu_a_sel      = '0;
    c_alu_b_sel      = 1'b0;
    c_alu_op         = '0;
    c_flags_mask     = '0;
    c_new_sreg_sel   = 1'b0;
    c_ex_out         = 1'b0;
    c_branch_mode    = 1'b0;
    c_pc_offset_mode = 1'b0;
    rd_addr          = '0;
    rr_addr          = '0;
    imm              = '0;
    rd_we            = 1'b0;
    sreg_we          = 1'b0;
    pc_inc           = 1'b0;
    pc_load          = 1'b0;
    illegal          = 1'b0;

    if (!rst && state != ST_FETCH) begin
      c_alu_a_sel      = ctrl.alu_a_sel;
      c_alu_b_sel      = ctrl.alu_b_sel;
      c_alu_op         = ctrl.alu_op;
      c_flags_mask     = ctrl.flags_mask;
      c_branch_mode    = ctrl.branch_mode;
      c_pc_offset_mode = ctrl.pc_offset_mode;
      rd_addr          = ctrl.rd_addr;
      rr_addr          = ctrl.rr_addr;
      imm              = ctrl.imm;
      c_new_sreg_sel   = 1'b1;
      c_ex_out         = 1'b1;
    end

    if (!rst) begin
      case (state)
        ST_FETCH: begin
          inst_ready = 1'b1;
          if (inst_valid) state_next = ST_EXEC;
        end
        ST_EXEC: begin
          case (cls)
            CL_ALU: begin
              rd_we      = ctrl.rd_we;
              sreg_we    = ctrl.sreg_we;
              pc_inc     = 1'b1;
              state_next = ST_FETCH;
            end
            CL_BRANCH: begin
              if (branch_taken) begin
                state_next = ST_BRANCH;
              end else begin
                pc_inc     = 1'b1;
                state_next = ST_FETCH;
              end
            end
            CL_RJMP: state_next = ST_BRANCH;
            CL_LPM: begin
              pm_req     = 1'b1;
              state_next = ST_LPM_WAIT;
            end
            default: begin
              illegal    = 1'b1;
              pc_inc     = 1'b1;
              state_next = ST_FETCH;
            end
          endcase
        end
        ST_BRANCH: begin
          pc_load    = 1'b1;
          state_next = ST_FETCH;
        end
        ST_LPM_WAIT: begin
          pm_req = 1'b1;
          if (pm_ack) state_next = ST_LPM_WB;
        end
        ST_LPM_WB: begin
          c_ex_out   = 1'b0;
          rd_we      = 1'b1;
          pc_inc     = 1'b1;
          state_next = ST_FETCH;
        end
        default: state_next = ST_FETCH;
      endcase
    end
  end

endmodule
